sprite_anim_ctrl: RTL
=====================

SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 Parameter ANIM_DIV, default 8: video frames per animation-column advance (1..255).
REQ-002 Parameter STEP, default 2: horizontal pixels moved per video frame while walking.
REQ-003 Parameter JUMP_V, default 12: initial upward speed in pixels/frame at jump start.
REQ-004 Parameter GROUND_Y, default 428: resting sprite top row (480-52).
REQ-005 Parameter MAX_X, default 608: rightmost sprite left column (640-32).
REQ-006 Clk  input  1  system clock; single clock domain.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 frame_clk  input  1  vertical-sync-rate level, synchronous to Clk; rising edge marks a new video frame.
REQ-009 keycode  input  8  current USB HID keycode; 8'h04 = left, 8'h07 = right, 8'h1A = jump, others = none.
REQ-010 shape_x  output  10  sprite left column for the color mapper.
REQ-011 shape_y  output  10  sprite top row for the color mapper.
REQ-012 sel  output  4  sprite-sheet cell index {row[1:0], col[1:0]}.
REQ-013 facing  output  1  0 = right, 1 = left.

Function
REQ-014 All outputs SHALL be registered; none combinationally depend on inputs.
REQ-015 frame_tick SHALL be 1 for exactly one Clk cycle: the cycle where frame_clk=1 and its registered previous sample=0.
REQ-016 State, position, counters and outputs SHALL update only at the Clk edge ending a frame_tick cycle; otherwise hold.
REQ-017 States: IDLE (row 0), WALK_R (row 1), WALK_L (row 2), JUMP (row 3); sel[3:2] SHALL equal the row of the current state.
REQ-018 IDLE/WALK_x transitions on tick: jump key -> JUMP; right key -> WALK_R; left key -> WALK_L; any other keycode -> IDLE.
REQ-019 Entering JUMP SHALL load vy = -JUMP_V; in JUMP each tick shape_y += vy then vy += 1 (signed, 8-bit vy).
REQ-020 In JUMP, if updated shape_y >= GROUND_Y (signed compare), shape_y SHALL become GROUND_Y and state SHALL become IDLE on that tick.
REQ-021 JUMP SHALL ignore further jump keys; left/right keys SHALL still move x and set facing during JUMP.
REQ-022 Right movement: shape_x = min(shape_x + STEP, MAX_X); left movement: shape_x = (shape_x < STEP) ? 0 : shape_x - STEP.
REQ-023 facing SHALL be set 0 on right movement, 1 on left movement, held otherwise.
REQ-024 anim_cnt counts ticks 0..ANIM_DIV-1; at wrap to 0, col (sel[1:0]) SHALL increment modulo 4 (3 -> 0).
REQ-025 Any state change SHALL clear anim_cnt and col to 0 on the same tick.
REQ-026 shape_y SHALL equal GROUND_Y in every state except JUMP.
REQ-027 frame_clk held high SHALL produce no further ticks until it falls and rises again.

Reset
REQ-028 Reset SHALL take priority over frame_tick in the same cycle.
REQ-029 Reset values: state IDLE, shape_x = 304, shape_y = GROUND_Y, sel = 0, facing = 0, vy = 0, anim_cnt = 0, frame_clk sample = 0.
REQ-030 Reset asserted mid-JUMP SHALL return to reset values at the next Clk edge with no residual velocity.

Verification
REQ-031 Reset, keycode 0, 16 ticks -> shape_x=304, shape_y=428, sel sequence 0,0 (x8), 1 after 8th tick, 2 after 16th.
REQ-032 keycode 8'h07 held 160 ticks from reset -> shape_x increases 2 per tick, saturates at 608 on tick 152, sel[3:2]=1, facing=0.
REQ-033 keycode 8'h04 one tick from shape_x=1 -> shape_x=0, state WALK_L, sel=8, facing=1.
REQ-034 keycode 8'h1A one tick at rest -> JUMP, sel=12; y sequence 416,405,395... returns to 428 and IDLE on tick 25, sel=0.
REQ-035 frame_clk held high 100 Clk cycles -> exactly one update; Reset and frame_tick same cycle -> reset values only.
REQ-036 Reset asserted during JUMP at shape_y=380 -> next edge shape_y=428, sel=0, later ticks show no vertical motion.

Source files
------------

// File: rtl/sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
// sprite_anim_ctrl : per-frame walk/jump controller and sprite-sheet selector
// Revision 1.0 - initial release
// ============================================================================
module sprite_anim_ctrl #(
    parameter int ANIM_DIV = 8,
    parameter int STEP     = 2,
    parameter int JUMP_V   = 12,
    parameter int GROUND_Y = 428,
    parameter int MAX_X    = 608
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] shape_x,
    output logic [9:0] shape_y,
    output logic [3:0] sel,
    output logic       facing
);

    // State encoding doubles as the sprite-sheet row.
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_walk_r = 2'd1;
    localparam logic [1:0] c_st_walk_l = 2'd2;
    localparam logic [1:0] c_st_jump   = 2'd3;

    localparam logic [7:0]        c_key_left  = 8'h04;
    localparam logic [7:0]        c_key_right = 8'h07;
    localparam logic [7:0]        c_key_jump  = 8'h1A;
    localparam logic [9:0]        c_reset_x   = 10'd304;
    localparam logic [9:0]        c_step      = 10'(STEP);
    localparam logic [9:0]        c_max_x     = 10'(MAX_X);
    localparam logic [9:0]        c_ground    = 10'(GROUND_Y);
    localparam logic [7:0]        c_anim_last = 8'(ANIM_DIV - 1);
    localparam logic signed [7:0] c_vy_launch = 8'(-JUMP_V);

    logic              r_frame_prev;
    logic [1:0]        r_state;
    logic [1:0]        r_col;
    logic [7:0]        r_anim_cnt;
    logic signed [7:0] r_vy;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic              r_facing;

    logic              w_frame_tick;
    logic              w_key_left;
    logic              w_key_right;
    logic              w_key_jump;
    logic [10:0]       w_x_right_sum;
    logic [9:0]        w_x_next;
    logic              w_facing_next;
    logic              w_jumping;
    logic signed [7:0] w_vy_eff;
    logic signed [11:0] w_y_sum;
    logic              w_landed;
    logic [1:0]        w_state_next;
    logic [9:0]        w_y_next;
    logic signed [7:0] w_vy_next;

    assign w_frame_tick = frame_clk & ~r_frame_prev;
    assign w_key_left   = (keycode == c_key_left);
    assign w_key_right  = (keycode == c_key_right);
    assign w_key_jump   = (keycode == c_key_jump);

    always_comb begin
        w_x_right_sum = {1'b0, r_x} + {1'b0, c_step};
        w_x_next      = r_x;
        w_facing_next = r_facing;
        if (w_key_right) begin
            w_x_next      = (w_x_right_sum > {1'b0, c_max_x}) ? c_max_x : w_x_right_sum[9:0];
            w_facing_next = 1'b0;
        end else if (w_key_left) begin
            w_x_next      = (r_x < c_step) ? 10'd0 : (r_x - c_step);
            w_facing_next = 1'b1;
        end
    end

    // The launch tick already applies the first upward step.
    always_comb begin
        w_jumping = (r_state == c_st_jump) || w_key_jump;
        w_vy_eff  = (r_state == c_st_jump) ? r_vy : c_vy_launch;
        w_y_sum   = $signed({2'b00, r_y}) + $signed({{4{w_vy_eff[7]}}, w_vy_eff});
        w_landed  = (w_y_sum >= $signed({2'b00, c_ground}));

        w_state_next = c_st_idle;
        w_y_next     = c_ground;
        w_vy_next    = 8'sd0;
        if (w_jumping) begin
            if (!w_landed) begin
                w_state_next = c_st_jump;
                w_y_next     = w_y_sum[9:0];
                w_vy_next    = w_vy_eff + 8'sd1;
            end
        end else if (w_key_right) begin
            w_state_next = c_st_walk_r;
        end else if (w_key_left) begin
            w_state_next = c_st_walk_l;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_prev <= 1'b0;
            r_state      <= c_st_idle;
            r_col        <= 2'd0;
            r_anim_cnt   <= 8'd0;
            r_vy         <= 8'sd0;
            r_x          <= c_reset_x;
            r_y          <= c_ground;
            r_facing     <= 1'b0;
        end else begin
            r_frame_prev <= frame_clk;
            if (w_frame_tick) begin
                r_state  <= w_state_next;
                r_x      <= w_x_next;
                r_y      <= w_y_next;
                r_vy     <= w_vy_next;
                r_facing <= w_facing_next;
                if (w_state_next != r_state) begin
                    r_anim_cnt <= 8'd0;
                    r_col      <= 2'd0;
                end else if (r_anim_cnt == c_anim_last) begin
                    r_anim_cnt <= 8'd0;
                    r_col      <= r_col + 2'd1;
                end else begin
                    r_anim_cnt <= r_anim_cnt + 8'd1;
                end
            end
        end
    end

    assign shape_x = r_x;
    assign shape_y = r_y;
    assign sel     = {r_state, r_col};
    assign facing  = r_facing;

endmodule
`default_nettype wire
